// File: rtl/ssram_wait_port.sv
// ssram_wait_port: single-port synchronous SRAM with a ready/acknowledge
// handshake, fixed read/write wait states and out-of-range reporting.
// A request is latched on acceptance in IDLE, held for READ_WAIT or
// WRITE_WAIT cycles in WAIT, performed on the edge entering RESP, and
// acknowledged with a one-cycle rdy pulse in RESP.
module ssram_wait_port #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_WAIT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read_enable,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_rdy,
  input  logic                    write_enable,
  input  logic [DATA_WIDTH/8-1:0] write_byte_enable,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic                    write_rdy,
  output logic                    busy,
  output logic                    range_err
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFFS   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] RD_WAIT = 4'(READ_WAIT);
  localparam logic [3:0] WR_WAIT = 4'(WRITE_WAIT);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  // Request captured at acceptance; later bus changes are ignored.
  logic                  op_write;
  logic [IDX_W-1:0]      lat_idx;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [BYTES-1:0]      lat_be;

  logic                  accept;
  logic                  accept_write;
  logic [3:0]            load_val;
  logic                  do_access;
  logic [IDX_W-1:0]      req_idx;

  logic                  acc_write;
  logic [IDX_W-1:0]      acc_idx;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [BYTES-1:0]      acc_be;
  logic                  acc_in_range;
  logic [MEM_AW-1:0]     mem_addr;
  logic                  lat_in_range;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Word index drops the byte-offset bits; misalignment is not an error.
  assign req_idx = IDX_W'(address >> OFFS);

  // Next-state logic: write wins over read in IDLE, WAIT counts down,
  // RESP always returns to IDLE after its single rdy cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    accept_write = 1'b0;
    load_val     = 4'd0;
    do_access    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (write_enable || read_enable) begin
          accept       = 1'b1;
          accept_write = write_enable;
          load_val     = write_enable ? WR_WAIT : RD_WAIT;
          cnt_nxt      = load_val;
          if (load_val != 4'd0) begin
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = ST_RESP;
            do_access = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = ST_RESP;
          do_access = 1'b1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Access operands come straight off the bus for zero-wait accesses,
  // otherwise from the latched request.
  always_comb begin
    acc_write = op_write;
    acc_idx   = lat_idx;
    acc_data  = lat_data;
    acc_be    = lat_be;
    if (state == ST_IDLE) begin
      acc_write = accept_write;
      acc_idx   = req_idx;
      acc_data  = write_data;
      acc_be    = write_byte_enable;
    end
  end

  assign acc_in_range = (acc_idx < DEPTH_IDX);
  assign mem_addr     = acc_idx[MEM_AW-1:0];
  assign lat_in_range = (lat_idx < DEPTH_IDX);

  // State, counter and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      op_write <= 1'b0;
      lat_idx  <= '0;
      lat_data <= '0;
      lat_be   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_write <= accept_write;
        lat_idx  <= req_idx;
        lat_data <= write_data;
        lat_be   <= write_byte_enable;
      end
    end
  end

  // Read port: registered on the edge entering RESP; out of range reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
    end else if (do_access && !acc_write) begin
      read_data <= acc_in_range ? mem[mem_addr] : '0;
    end
  end

  // Byte-strobed write, suppressed by reset and for out-of-range indices.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_write && acc_in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (acc_be[b]) begin
          mem[mem_addr][b*8 +: 8] <= acc_data[b*8 +: 8];
        end
      end
    end
  end

  assign read_rdy  = (state == ST_RESP) && !op_write;
  assign write_rdy = (state == ST_RESP) && op_write;
  assign busy      = (state != ST_IDLE);
  assign range_err = (state == ST_RESP) && !lat_in_range;

endmodule

// File: tb/tb_ssram_wait_port.sv
// tb_ssram_wait_port: directed, table-driven bench for ssram_wait_port.
// Instance a: READ_WAIT=2, WRITE_WAIT=0. Instance b: READ_WAIT=1, WRITE_WAIT=3.
module tb_ssram_wait_port;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  write_byte_enable;
  logic        a_re, a_we, b_re, b_we;
  logic [31:0] a_read_data, b_read_data;
  logic        a_read_rdy, a_write_rdy, a_busy, a_range_err;
  logic        b_read_rdy, b_write_rdy, b_busy, b_range_err;

  int total;
  int passed;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  ssram_wait_port #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(16),
    .READ_WAIT(2), .WRITE_WAIT(0)
  ) u_a (
    .clk(clk), .rst(rst), .address(address),
    .read_enable(a_re), .read_data(a_read_data), .read_rdy(a_read_rdy),
    .write_enable(a_we), .write_byte_enable(write_byte_enable),
    .write_data(write_data), .write_rdy(a_write_rdy),
    .busy(a_busy), .range_err(a_range_err)
  );

  ssram_wait_port #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(16),
    .READ_WAIT(1), .WRITE_WAIT(3)
  ) u_b (
    .clk(clk), .rst(rst), .address(address),
    .read_enable(b_re), .read_data(b_read_data), .read_rdy(b_read_rdy),
    .write_enable(b_we), .write_byte_enable(write_byte_enable),
    .write_data(write_data), .write_rdy(b_write_rdy),
    .busy(b_busy), .range_err(b_range_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison with pass/fail bookkeeping.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic rdy_of(input int sel, input logic wr);
    if (sel == 0) return wr ? a_write_rdy : a_read_rdy;
    return wr ? b_write_rdy : b_read_rdy;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? a_busy : b_busy;
  endfunction

  function automatic logic err_of(input int sel);
    return (sel == 0) ? a_range_err : b_range_err;
  endfunction

  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? a_read_data : b_read_data;
  endfunction

  task automatic set_en(input int sel, input logic we, input logic re);
    if (sel == 0) begin
      a_we = we;
      a_re = re;
    end else begin
      b_we = we;
      b_re = re;
    end
  endtask

  // One complete transaction: checks latency, busy span, rdy exclusivity
  // and busy dropping after the pulse; returns range_err and read_data.
  task automatic apply_stimulus(input string name, input int sel, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int exp_lat,
                                output logic err, output logic [31:0] rd);
    int   lat;
    logic busy_ok;
    logic excl_ok;
    address           = addr;
    write_data        = wdata;
    write_byte_enable = be;
    set_en(sel, wr, !wr);
    tick();
    lat     = 1;
    busy_ok = 1'b1;
    excl_ok = 1'b1;
    while (!rdy_of(sel, wr) && lat < 20) begin
      if (!busy_of(sel)) busy_ok = 1'b0;
      if (rdy_of(sel, !wr)) excl_ok = 1'b0;
      tick();
      lat++;
    end
    if (!busy_of(sel)) busy_ok = 1'b0;
    if (rdy_of(sel, !wr)) excl_ok = 1'b0;
    err = err_of(sel);
    rd  = rdata_of(sel);
    set_en(sel, 1'b0, 1'b0);
    check_output({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check_output({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check_output({name, "_excl"}, {31'd0, excl_ok}, 32'd1);
    tick();
    check_output({name, "_busy_after"}, {31'd0, busy_of(sel)}, 32'd0);
  endtask

  initial begin
    logic        err;
    logic [31:0] rd;
    int          cyc, w_at, r_at, p1, p2;
    logic        both;
    logic        seen;

    total = 0;
    passed = 0;
    rst = 1'b1;
    address = '0;
    write_data = '0;
    write_byte_enable = '0;
    a_re = 0; a_we = 0; b_re = 0; b_we = 0;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h00C0_FFEE, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0008, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'h5, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'hAA22_AA44, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_000B, 32'h5566_7788, 4'h0, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_000A, 32'h0, 4'h0, 32'hAA22_AA44, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_000F, 32'h1234_5678, 4'hA, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h12FE_560D, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h00C0_FFEE, 1'b0};
    vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[13] = '{1'b1, 32'h0000_003C, 32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_003D, 32'h0, 4'h0, 32'h0BAD_C0DE, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};

    // Reset state of both instances.
    tick();
    tick();
    check_output("rst_a_outs", {a_read_data[27:0], a_read_rdy, a_write_rdy, a_busy, a_range_err}, 32'd0);
    check_output("rst_b_outs", {b_read_data[27:0], b_read_rdy, b_write_rdy, b_busy, b_range_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Preload word 5 and read it with READ_WAIT=2.
    apply_stimulus("a_pre", 0, 1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, 1, err, rd);
    apply_stimulus("a_rd5", 0, 1'b0, 32'h14, 32'h0, 4'h0, 3, err, rd);
    check_output("a_rd5_data", rd, 32'hDEAD_BEEF);
    check_output("a_rd5_err", {31'd0, err}, 32'd0);
    tick();
    tick();
    check_output("a_rd5_hold", a_read_data, 32'hDEAD_BEEF);

    // Table-driven transactions on instance a.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus($sformatf("vec%0d", i), 0, vecs[i].wr, vecs[i].addr, vecs[i].data,
                     vecs[i].be, vecs[i].wr ? 1 : 3, err, rd);
      check_output($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      if (!vecs[i].wr) check_output($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
    end

    // Simultaneous read and write at the same address: write first.
    address = 32'h10;
    write_data = 32'h5A5A_5A5A;
    write_byte_enable = 4'hF;
    a_we = 1; a_re = 1;
    cyc = 0; w_at = -1; r_at = -1; both = 0; rd = '0;
    while (r_at < 0 && cyc < 30) begin
      tick();
      cyc++;
      if (a_write_rdy && a_read_rdy) both = 1;
      if (a_write_rdy && w_at < 0) begin
        w_at = cyc;
        a_we = 0;
      end
      if (a_read_rdy && r_at < 0) begin
        r_at = cyc;
        a_re = 0;
        rd = a_read_data;
      end
    end
    a_we = 0; a_re = 0;
    check_output("simul_write_first", 32'(w_at), 32'd1);
    check_output("simul_spacing", {31'd0, (w_at > 0) && (r_at - w_at >= 4)}, 32'd1);
    check_output("simul_both_rdy", {31'd0, both}, 32'd0);
    check_output("simul_data", rd, 32'h5A5A_5A5A);
    tick();

    // Instance b: preload, then a held read gives pulses WAIT+2 apart.
    apply_stimulus("b_pre", 1, 1'b1, 32'h04, 32'h1357_9BDF, 4'hF, 4, err, rd);
    address = 32'h04;
    b_re = 1;
    cyc = 0; p1 = -1; p2 = -1;
    while (p2 < 0 && cyc < 30) begin
      tick();
      cyc++;
      if (b_read_rdy) begin
        if (p1 < 0) p1 = cyc;
        else p2 = cyc;
      end
    end
    b_re = 0;
    check_output("b_held_first", 32'(p1), 32'd2);
    check_output("b_held_spacing", 32'(p2 - p1), 32'd3);
    check_output("b_held_data", b_read_data, 32'h1357_9BDF);
    tick();

    // Request latched at acceptance: enable drops and address changes.
    address = 32'h04;
    b_re = 1;
    tick();
    b_re = 0;
    address = 32'h08;
    cyc = 1;
    while (!b_read_rdy && cyc < 10) begin
      tick();
      cyc++;
    end
    check_output("b_latch_latency", 32'(cyc), 32'd2);
    check_output("b_latch_data", b_read_data, 32'h1357_9BDF);
    tick();

    // Reset in the middle of a write wait aborts the write.
    address = 32'h04;
    write_data = 32'hFFFF_0000;
    write_byte_enable = 4'hF;
    b_we = 1;
    tick();
    check_output("b_abort_busy", {31'd0, b_busy}, 32'd1);
    tick();
    rst = 1'b1;
    b_we = 0;
    tick();
    check_output("abort_b_outs", {b_read_data[27:0], b_read_rdy, b_write_rdy, b_busy, b_range_err}, 32'd0);
    check_output("abort_a_rdata", a_read_data, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (b_write_rdy || b_busy) seen = 1;
    end
    check_output("abort_no_rdy", {31'd0, seen}, 32'd0);
    apply_stimulus("b_post_rd", 1, 1'b0, 32'h04, 32'h0, 4'h0, 2, err, rd);
    check_output("b_post_rd_data", rd, 32'h1357_9BDF);
    apply_stimulus("b_post_wr", 1, 1'b1, 32'h08, 32'h2468_1357, 4'hF, 4, err, rd);
    apply_stimulus("b_post_rd2", 1, 1'b0, 32'h08, 32'h0, 4'h0, 2, err, rd);
    check_output("b_post_rd2_data", rd, 32'h2468_1357);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ssram_wait_port.md
# ssram_wait_port

Parametrised single-port synchronous SRAM with a ready/acknowledge handshake and programmable wait states, replacing the always-ready code/data memories in the CPU top level. It presents the same bus the rv32i core drives (enable, address, byte enables, data, ready), holds the requester for a fixed number of read or write wait cycles, and reports out-of-range accesses. One instance serves the code port and one the data port; each instance is configured independently.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8.
- ADDR_WIDTH, 32: width of the incoming byte address.
- DEPTH_WORDS, 1024: number of words stored.
- READ_WAIT, 2: extra cycles inserted before read_rdy; 0..15.
- WRITE_WAIT, 1: extra cycles inserted before write_rdy; 0..15.
- clk  in  1  clock; one clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  byte address; word index = address >> log2(DATA_WIDTH/8).
- read_enable  in  1  read request, held until read_rdy.
- read_data  out  DATA_WIDTH  read word, valid while read_rdy is high, held until the next read completes.
- read_rdy  out  1  one-cycle read completion pulse.
- write_enable  in  1  write request, held until write_rdy.
- write_byte_enable  in  DATA_WIDTH/8  per-byte write strobes.
- write_data  in  DATA_WIDTH  write word.
- write_rdy  out  1  one-cycle write completion pulse.
- busy  out  1  high from acceptance until the cycle after the rdy pulse.
- range_err  out  1  pulses with rdy when the word index is >= DEPTH_WORDS.

## Operation
- States: IDLE, WAIT, RESP. A down-counter (4 bits) counts the wait cycles.
- IDLE:
  - write_enable high: latch address, data and strobes, and mark the operation as a write.
  - Otherwise, read_enable high: latch the address and mark the operation as a read.
  - Load the counter with WRITE_WAIT or READ_WAIT. Go to WAIT if that value is nonzero, else go straight to RESP.
- Simultaneous read_enable and write_enable: the write is served first. The read is served on a later acceptance while the requester still holds read_enable. No request is dropped.
- WAIT: decrement the counter each cycle. Go to RESP on the cycle the counter is 1.
- On the clock edge that enters RESP, the access is performed:
  - A write updates only the bytes whose strobe is set; all-zero strobes leave memory unchanged.
  - A read registers mem[index] into read_data.
- RESP:
  - Assert read_rdy or write_rdy for exactly one cycle; only one rdy is ever high.
  - Assert range_err in the same cycle if the latched index is out of range. An out-of-range write changes no memory; an out-of-range read returns 0.
  - Next state is IDLE.
- The request is latched at acceptance. Changes to address, data or enables during WAIT are ignored, and the access completes even if the enable drops.
- Low address bits below word granularity are ignored; no misalignment error is raised.
- Reset:
  - Outputs: read_data=0, read_rdy=0, write_rdy=0, busy=0, range_err=0; state IDLE; counter 0.
  - Memory contents are not cleared.
  - Reset during WAIT aborts the access: no write is committed and no rdy is issued.

## Timing
- A request is sampled in IDLE on edge T. Its rdy is high in cycle T+WAIT+1, where WAIT is READ_WAIT or WRITE_WAIT.
- A request held through its rdy cycle is sampled again in IDLE. Minimum spacing between rdy pulses of back-to-back requests is WAIT+2 cycles.
- busy is high from cycle T+1 through the rdy cycle.
- read_data changes only on an edge that enters RESP for a read, or on reset.

## Test plan
- Reset, then READ_WAIT=2, read at word 5 preloaded with 0xDEADBEEF: read_rdy high exactly 3 cycles after acceptance with read_data=0xDEADBEEF. read_data is held after the pulse; busy spans T+1..T+3.
- WRITE_WAIT=0, write 0x11223344 with strobes 4'b0101 over 0xAAAAAAAA: write_rdy at T+1. A subsequent read returns 0xAA22AA44.
- read_enable and write_enable together at the same address: write_rdy first, then read_rdy WAIT+2 or more cycles later. The read returns the new data; no cycle has both rdy signals high.
- Address 4*DEPTH_WORDS, read and write: each rdy pulses together with range_err. The read returns 0 and no in-range word changes.
- rst asserted mid-WAIT of a write: all outputs 0 next cycle, no write_rdy, target word unchanged. A new request after reset completes normally.
